// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and WHO/hint codes for the round engine and its score counter.
package game_pkg;
  typedef enum logic [2:0] {IDLE, ARM, WAIT, JUDGE, SETTLE, HOLD} state_t;
  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;
  localparam logic [1:0] HINT_NONE  = 2'b00;
  localparam logic [1:0] HINT_LOW   = 2'b01;
  localparam logic [1:0] HINT_HIGH  = 2'b10;
endpackage

// File: rtl/lfsr8.sv
// lfsr8: free-running 8-bit Galois LFSR, x^8+x^6+x^5+x^4+1, stepping every cycle.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= SEED;
    else q <= {1'b0, q[7:1]} ^ (q[0] ? 8'hB8 : 8'h00);
endmodule

// File: rtl/round_judge.sv
// round_judge: latches a random target, judges guesses into WINNER/LOSER pulses, freezes on counter gameover.
// Define ROUND_TIMEOUT_EN to turn an unanswered WAIT into an automatic miss after TIMEOUT cycles.
module round_judge
  import game_pkg::*;
#(
  parameter int         W       = 4,
  parameter logic [7:0] SEED    = 8'hA5,
  parameter int         TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         guess_valid,
  input  logic [W-1:0] guess,
  output logic         guess_ready,
  input  logic         gameover,
  input  logic [1:0]   who,
  output logic         WINNER,
  output logic         LOSER,
  output logic [1:0]   hint,
  output logic         game_done,
  output logic [1:0]   final_who
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  state_t state, nxt;
  logic [7:0] lfsr_q;
  logic [W-1:0] target;
  logic hit, take, tmo;
  logic unused_lfsr;
  lfsr8 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .q(lfsr_q));
  assign unused_lfsr = ^lfsr_q;
  // gameover outranks a guess, so no handshake may complete while it is high
  assign guess_ready = state == WAIT && !gameover;
  assign take        = guess_valid && guess_ready;
  assign WINNER      = state == JUDGE && hit;
  assign LOSER       = state == JUDGE && !hit;
  assign game_done   = state == HOLD;
`ifdef ROUND_TIMEOUT_EN
  logic [TW-1:0] timer;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else timer <= state == WAIT ? timer + TW'(1) : '0;
  assign tmo = state == WAIT && timer == TLAST && !take && !gameover;
`else
  logic unused_timeout;
  assign unused_timeout = ^TLAST;
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ARM : IDLE;
      ARM:     nxt = WAIT;
      WAIT:    nxt = take || tmo ? JUDGE : WAIT;
      JUDGE:   nxt = SETTLE;
      SETTLE:  nxt = ARM;
      HOLD:    nxt = start ? ARM : HOLD;
      default: nxt = IDLE;
    endcase
    if (gameover) nxt = HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      target    <= '0;
      hit       <= 1'b0;
      hint      <= HINT_NONE;
      final_who <= WHO_NONE;
    end else begin
      state <= nxt;
      if (state == ARM) target <= lfsr_q[W-1:0];
      if (take) begin
        hit  <= guess == target;
        hint <= guess == target ? HINT_NONE : guess < target ? HINT_LOW : HINT_HIGH;
      end else if (tmo) begin
        hit  <= 1'b0;
        hint <= HINT_NONE;
      end
      final_who <= gameover ? who : state == HOLD && start ? WHO_NONE : final_who;
    end
endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge: randomized scoreboard bench for round_judge with a behavioural score counter attached.
module tb_round_judge;
  import game_pkg::*;
  typedef struct {logic win; logic [1:0] hint; int cyc;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, guess_valid = 0;
  logic [3:0] guess = 0;
  logic guess_ready, gameover, WINNER, LOSER, game_done;
  logic [1:0] who, hint, final_who;
  int cyc = 0, pass_cnt = 0, total = 0, npulse = 0, lp = -1, rise_cyc = 0;
  int wins = 0, losses = 0;
  logic [7:0] m_lfsr, lf_d = 8'hA5;
  logic [3:0] tgt = 0;
  logic rdy_d = 0, gd_d = 0;
  exp_t q[$];
  logic [1:0] gq[$];

  round_judge #(.W(4), .SEED(8'hA5), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .guess_valid(guess_valid), .guess(guess),
    .guess_ready(guess_ready), .gameover(gameover), .who(who), .WINNER(WINNER), .LOSER(LOSER),
    .hint, .game_done(game_done), .final_who(final_who));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  function automatic logic [1:0] hint_of(input logic [3:0] g, input logic [3:0] t);
    return g == t ? 2'b00 : g < t ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) $display("FAIL %s: got %0h, want %0h", name, act, want);
    else pass_cnt++;
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 8'hA5;
    else m_lfsr <= lfsr_next(m_lfsr);

  // score counter: first side to 15 judged pulses ends the game
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wins <= 0; losses <= 0; gameover <= 0; who <= 2'b00;
    end else begin
      gameover <= 0;
      who <= 2'b00;
      if (WINNER) begin
        if (wins == 14) begin
          gameover <= 1; who <= 2'b10; wins <= 0; losses <= 0; gq.push_back(2'b10);
        end else wins <= wins + 1;
      end else if (LOSER) begin
        if (losses == 14) begin
          gameover <= 1; who <= 2'b01; wins <= 0; losses <= 0; gq.push_back(2'b01);
        end else losses <= losses + 1;
      end
    end

  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_d = 0; gd_d = 0; lp = -1;
    end else begin
      if (WINNER || LOSER) begin
        exp_t e;
        npulse++;
        chk("pulse_exclusive", 32'(WINNER && LOSER), 0);
        if (q.size() == 0) fail("unexpected_pulse");
        else begin
          e = q.pop_front();
          chk("pulse_value", {WINNER, LOSER, hint}, {e.win, !e.win, e.hint});
          chk("pulse_latency", cyc, e.cyc);
        end
        lp = cyc;
      end
      if (guess_ready && !rdy_d) begin
        tgt = lf_d[3:0];
        rise_cyc = cyc;
        if (lp >= 0) chk("pulse_to_ready", cyc - lp, 3);
        lp = -1;
      end
      if (game_done && !gd_d) begin
        lp = -1;
        if (gq.size() == 0) fail("unexpected_hold");
        else begin
          logic [1:0] w;
          w = gq.pop_front();
          chk("final_who", final_who, w);
        end
      end
      rdy_d = guess_ready;
      gd_d = game_done;
    end
    lf_d = m_lfsr;
  end

  task automatic kick();
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  // kind: 0 hit, 1 target+1, 2 target-1, else random value; returns just after the accept edge
  task automatic play(input int kind, input bit track);
    int n;
    logic [3:0] g;
    n = 0;
    do begin
      @(negedge clk);
      #2 n++;
      if (game_done) kick();
    end while (!guess_ready && n < 200);
    if (!guess_ready) begin
      fail("ready_wait");
      return;
    end
    g = kind == 0 ? tgt : kind == 1 ? tgt + 4'd1 : kind == 2 ? tgt - 4'd1 : 4'($urandom_range(0, 15));
    guess = g;
    guess_valid = 1;
    @(posedge clk);
    #1 guess_valid = 0;
    if (track) q.push_back('{g == tgt, hint_of(g, tgt), cyc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {WINNER, LOSER, hint, game_done, final_who, guess_ready}, 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_lfsr", dut.lfsr_q, 8'hA5);
    #2 rst_n = 1;
    guess_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_not_ready", guess_ready, 0);
    end
    #2 guess_valid = 0;
    kick();
    play(0, 1);
    play(1, 1);
    play(2, 1);
    for (int i = 0; i < 40; i++) play($urandom_range(0, 3), 1);
    repeat (4) @(negedge clk);
    // fresh game: 15 straight hits must end it as a win
    #2 rst_n = 0;
    @(negedge clk);
    #2 rst_n = 1;
    kick();
    for (int i = 0; i < 15; i++) play(0, 1);
    for (n0 = 0; n0 < 10 && !game_done; n0++) @(negedge clk);
    chk("hold_game_done", game_done, 1);
    chk("hold_final_who", final_who, 2'b10);
    #2 kick();
    chk("restart_state", 32'(dut.state), 32'(ARM));
    chk("restart_clear", {game_done, final_who}, 0);
`ifdef ROUND_TIMEOUT_EN
    @(negedge clk);
    #2 q.push_back('{1'b0, 2'b00, rise_cyc + 16});
    repeat (20) @(negedge clk);
    chk("timeout_drained", q.size(), 0);
`else
    n0 = npulse;
    repeat (100) @(negedge clk);
    chk("no_timeout_pulse", npulse, n0);
`endif
    play(0, 0);
    chk("judge_pulse", {WINNER, LOSER}, 2'b10);
    rst_n = 0;
    #1 chk("async_drop", {WINNER, LOSER}, 0);
    @(negedge clk);
    #2 rst_n = 1;
    #1 chk("post_rst_state", 32'(dut.state), 32'(IDLE));
    chk("post_rst_lfsr", dut.lfsr_q, 8'hA5);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
